// File: rtl/hsync_generator_pkg.sv
// ----------------------------------------------------------------------------
// hsync_generator_pkg : shared VGA horizontal timing encodings and defaults
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hsync_generator_pkg;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_BACK   = 3'd2,
    ST_SYNC   = 3'd3,
    ST_FRONT  = 3'd4
  } state_e;

  typedef logic [1:0] phase_idx_t;

  localparam int NUM_PHASES      = 4;
  localparam int DEF_XRESOLUTION = 10;

  // 640x480 line timing in pixel periods
  localparam int DEF_ACTIVE = 640;
  localparam int DEF_BACK   = 48;
  localparam int DEF_SYNC   = 96;
  localparam int DEF_FRONT  = 16;

  // Phase index 0..3 maps onto the state code 1..4 in line order.
  function automatic state_e phase_state(input phase_idx_t idx);
    return state_e'({1'b0, idx} + 3'd1);
  endfunction

  function automatic state_e first_nz_from(input logic [NUM_PHASES-1:0] nz,
                                           input logic [2:0]            from);
    state_e r;
    r = ST_START;
    for (int i = NUM_PHASES - 1; i >= 0; i--) begin
      if (nz[2'(i)] && (3'(i) >= from)) begin
        r = phase_state(2'(i));
      end
    end
    return r;
  endfunction

  function automatic state_e last_nz(input logic [NUM_PHASES-1:0] nz);
    state_e r;
    r = ST_START;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (nz[2'(i)]) begin
        r = phase_state(2'(i));
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hsync_generator_if.sv
// ----------------------------------------------------------------------------
// hsync_generator_if : timing inputs and line-timing outputs of the hsync stage
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface hsync_generator_if
  import hsync_generator_pkg::*;
#(
  parameter int XRESOLUTION = DEF_XRESOLUTION
) ();

  logic [XRESOLUTION-1:0] ActiveVideo;
  logic [XRESOLUTION-1:0] BackPorch;
  logic [XRESOLUTION-1:0] SynchPulse;
  logic [XRESOLUTION-1:0] FrontPorch;

  logic                   hsync;
  logic [XRESOLUTION-1:0] xposition;
  logic                   videoOn;
  logic                   LineEnd;
  logic                   pixelTick;

  modport master (
    output ActiveVideo, BackPorch, SynchPulse, FrontPorch,
    input  hsync, xposition, videoOn, LineEnd, pixelTick
  );

  modport slave (
    input  ActiveVideo, BackPorch, SynchPulse, FrontPorch,
    output hsync, xposition, videoOn, LineEnd, pixelTick
  );

endinterface

`default_nettype wire

// File: rtl/hsync_generator_pixel_tick_divider.sv
// ----------------------------------------------------------------------------
// pixel_tick_divider : one-clock pixel strobe every PIXEL_DIV system clocks
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pixel_tick_divider
  import hsync_generator_pkg::*;
#(
  parameter int unsigned PIXEL_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  output logic pixelTick
);

  localparam int unsigned      CW   = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
  localparam logic [CW-1:0]    LAST = CW'(PIXEL_DIV - 1);

  logic [CW-1:0] div_q, div_d;
  logic          tick_q, tick_d;

  // The strobe is registered from the next count so it is high exactly while
  // the counter sits at LAST, and stays low throughout reset.
  always_comb begin
    div_d  = (div_q == LAST) ? '0 : div_q + CW'(1);
    tick_d = (div_d == LAST);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign pixelTick = tick_q;

endmodule

`default_nettype wire

// File: rtl/hsync_generator.sv
// ----------------------------------------------------------------------------
// hsync_generator : per-line phase sequencer producing hsync, x, videoOn, LineEnd
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hsync_generator
  import hsync_generator_pkg::*;
#(
  parameter int          XRESOLUTION = DEF_XRESOLUTION,
  parameter int unsigned PIXEL_DIV   = 4,
  parameter bit          HSYNC_POL   = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  hsync_generator_if.slave  bus
);

  typedef logic [XRESOLUTION-1:0] xval_t;

  logic pixel_tick;

  pixel_tick_divider #(
    .PIXEL_DIV (PIXEL_DIV)
  ) u_pixel_tick_divider (
    .clock     (clock),
    .reset     (reset),
    .pixelTick (pixel_tick)
  );

  state_e                  state_q, state_d;
  xval_t                   count_q, count_d;
  xval_t                   shadow_q [NUM_PHASES];
  xval_t                   shadow_d [NUM_PHASES];
  logic                    hsync_q, hsync_d;
  xval_t                   xpos_q, xpos_d;
  logic                    video_on_q, video_on_d;
  logic                    line_end_q, line_end_d;

  xval_t                   in_timing [NUM_PHASES];
  logic [NUM_PHASES-1:0]   in_nz, cur_nz, nxt_nz;
  phase_idx_t              cur_idx, nxt_idx;
  xval_t                   cur_len;
  logic                    last_tick;
  logic                    relatch;

  assign in_timing[0] = bus.ActiveVideo;
  assign in_timing[1] = bus.BackPorch;
  assign in_timing[2] = bus.SynchPulse;
  assign in_timing[3] = bus.FrontPorch;

  for (genvar g = 0; g < NUM_PHASES; g++) begin : g_phase_nz
    assign in_nz[g]  = (in_timing[g] != '0);
    assign cur_nz[g] = (shadow_q[g] != '0);
  end

  assign cur_idx   = 2'(state_q - 3'd1);
  assign cur_len   = shadow_q[cur_idx];
  assign last_tick = (({1'b0, count_q} + 1'b1) == {1'b0, cur_len});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_START;
      count_q <= '0;
      shadow_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shadow_q <= shadow_d;
    end
  end

  // Next phase / count. Zero-length phases are skipped in the same tick, and
  // the timing inputs are only sampled when a new line begins.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    relatch  = 1'b0;

    if (pixel_tick) begin
      if (state_q == ST_START) begin
        relatch = 1'b1;
        state_d = first_nz_from(in_nz, 3'd0);
        count_d = '0;
      end else if (last_tick) begin
        count_d = '0;
        state_d = first_nz_from(cur_nz, state_q);
        if (state_d == ST_START) begin
          relatch = 1'b1;
          state_d = first_nz_from(in_nz, 3'd0);
        end
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    if (relatch) begin
      shadow_d = in_timing;
    end
  end

  assign nxt_nz  = relatch ? in_nz : cur_nz;
  assign nxt_idx = 2'(state_d - 3'd1);

  always_comb begin
    video_on_d = (state_d == ST_ACTIVE);
    xpos_d     = video_on_d ? count_d : '0;
    hsync_d    = (state_d == ST_SYNC) ? HSYNC_POL : ~HSYNC_POL;
    line_end_d = (state_d != ST_START)
              && (state_d == last_nz(nxt_nz))
              && (({1'b0, count_d} + 1'b1) == {1'b0, shadow_d[nxt_idx]});
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hsync_q    <= ~HSYNC_POL;
      xpos_q     <= '0;
      video_on_q <= 1'b0;
      line_end_q <= 1'b0;
    end else begin
      hsync_q    <= hsync_d;
      xpos_q     <= xpos_d;
      video_on_q <= video_on_d;
      line_end_q <= line_end_d;
    end
  end

  assign bus.hsync     = hsync_q;
  assign bus.xposition = xpos_q;
  assign bus.videoOn   = video_on_q;
  assign bus.LineEnd   = line_end_q;
  assign bus.pixelTick = pixel_tick;

endmodule

`default_nettype wire
